// File: rtl/byte_issue.sv
// byte_issue: issue stage and fixed-latency result pipe for the byte ALU, with hazard stall and writeback forwarding
// Ports: clk/reset (sync, active-high); in_* = decoded instruction + operands (in_ready = accept this cycle);
//        flush drops everything in flight; alu_* = registered S0 operands, alu_result = combinational ALU answer;
//        wb_* = last result stage; inflight = valid entries in S0..S(LATENCY-1).
module byte_issue #(
    parameter int LATENCY = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [6:0]   in_instr_id,
    input  logic [6:0]   in_rt_addr,
    input  logic [6:0]   in_ra_addr,
    input  logic [6:0]   in_rb_addr,
    input  logic         in_uses_rb,
    input  logic [127:0] in_ra_data,
    input  logic [127:0] in_rb_data,
    input  logic         flush,
    output logic [6:0]   alu_instr_id,
    output logic [127:0] alu_ra_data,
    output logic [127:0] alu_rb_data,
    input  logic [127:0] alu_result,
    output logic         wb_valid,
    output logic [6:0]   wb_rt_addr,
    output logic [127:0] wb_data,
    output logic [2:0]   inflight
);
    localparam int N = LATENCY - 1;
    logic         s0_v_q, s0_v_d;
    logic [6:0]   s0_id_q, s0_id_d, s0_rt_q, s0_rt_d;
    logic [127:0] s0_ra_q, s0_ra_d, s0_rb_q, s0_rb_d;
    logic [N:1]   v_q, v_d;
    logic [6:0]   rt_q [1:N];
    logic [6:0]   rt_d [1:N];
    logic [127:0] dt_q [1:N];
    logic [127:0] dt_d [1:N];
    logic         hz, acc, fa, fb;
    logic [2:0]   cnt;
    always_comb begin
        // the writeback stage is not a hazard: its value is forwarded instead
        hz = s0_v_q && (in_ra_addr == s0_rt_q || (in_uses_rb && in_rb_addr == s0_rt_q));
        for (int i = 1; i < N; i++)
            hz = hz || (v_q[i] && (in_ra_addr == rt_q[i] || (in_uses_rb && in_rb_addr == rt_q[i])));
        in_ready = !hz && !flush && !reset;
        acc = in_valid && in_ready;
        fa = wb_valid && in_ra_addr == wb_rt_addr;
        fb = in_uses_rb && wb_valid && in_rb_addr == wb_rt_addr;
        s0_v_d  = acc;
        s0_id_d = acc ? in_instr_id : '0;
        s0_rt_d = acc ? in_rt_addr : '0;
        s0_ra_d = acc ? (fa ? wb_data : in_ra_data) : '0;
        s0_rb_d = acc ? (fb ? wb_data : in_rb_data) : '0;
        // bubbles carry zero payload so wb_* stay clean after reset
        v_d[1]  = s0_v_q && !flush;
        rt_d[1] = s0_v_q ? s0_rt_q : '0;
        dt_d[1] = s0_v_q ? alu_result : '0;
        for (int i = 2; i <= N; i++) begin
            v_d[i]  = v_q[i-1] && !flush;
            rt_d[i] = rt_q[i-1];
            dt_d[i] = dt_q[i-1];
        end
        cnt = {2'b00, s0_v_q};
        for (int i = 1; i <= N; i++)
            cnt = cnt + {2'b00, v_q[i]};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            s0_v_q  <= 1'b0;
            s0_id_q <= '0;
            s0_rt_q <= '0;
            s0_ra_q <= '0;
            s0_rb_q <= '0;
            v_q     <= '0;
            for (int i = 1; i <= N; i++) begin
                rt_q[i] <= '0;
                dt_q[i] <= '0;
            end
        end else begin
            s0_v_q  <= s0_v_d;
            s0_id_q <= s0_id_d;
            s0_rt_q <= s0_rt_d;
            s0_ra_q <= s0_ra_d;
            s0_rb_q <= s0_rb_d;
            v_q     <= v_d;
            rt_q    <= rt_d;
            dt_q    <= dt_d;
        end
    end
    assign alu_instr_id = s0_id_q;
    assign alu_ra_data  = s0_ra_q;
    assign alu_rb_data  = s0_rb_q;
    assign wb_valid     = v_q[N];
    assign wb_rt_addr   = rt_q[N];
    assign wb_data      = dt_q[N];
    assign inflight     = cnt;
endmodule
